// File: rtl/modulo_mef_enchimento_vedacao_temporizada.sv
// Fill/seal station controller: one bottle at a time, timed fill with fault, timed seal pulse,
// cork stock with saturating refill, and a wrapping sealed-bottle counter.
module modulo_mef_enchimento_vedacao_temporizada #(
  parameter int FILL_TIMEOUT = 64,
  parameter int SEAL_CYCLES  = 4,
  parameter int CORK_W       = 7,
  parameter int MAX_CORKS    = 100,
  parameter int REFILL_QTY   = 15,
  parameter int INIT_CORKS   = 0,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pg,
  input  logic               ch,
  input  logic               eb,
  input  logic               rep,
  output logic               m,
  output logic               ev,
  output logic               ve,
  output logic               al,
  output logic               flt,
  output logic [CORK_W-1:0]  rolhas,
  output logic [COUNT_W-1:0] garrafas,
  output logic [2:0]         estado
);

  // state  | meaning
  // IDLE   | stopped, all outputs off
  // MOVE   | conveyor runs until a bottle is present
  // FILL   | valve open until full, timeout leads to FAULT
  // SEAL   | sealing actuator pulse of SEAL_CYCLES cycles
  // NOCORK | seal pending but cork stock empty, alarm on
  // EXIT   | conveyor carries the sealed bottle away
  // FAULT  | fill timeout, waits for enable low
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE   = 3'd1,
    FILL   = 3'd2,
    SEAL   = 3'd3,
    NOCORK = 3'd4,
    EXIT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam int FT_W = $clog2(FILL_TIMEOUT);
  localparam int ST_W = $clog2(SEAL_CYCLES + 1);
  localparam logic [FT_W-1:0]   FILL_LAST  = FT_W'(FILL_TIMEOUT - 1);
  localparam logic [ST_W-1:0]   SEAL_LAST  = ST_W'(SEAL_CYCLES - 1);
  localparam logic [CORK_W:0]   REFILL_EXT = (CORK_W + 1)'(REFILL_QTY);
  localparam logic [CORK_W:0]   MAX_EXT    = (CORK_W + 1)'(MAX_CORKS);
  localparam logic [CORK_W-1:0] INIT_VAL   = CORK_W'(INIT_CORKS);

  state_t            state, state_next;
  logic [FT_W-1:0]   fill_timer;
  logic [ST_W-1:0]   seal_timer;
  logic              rep_q;
  logic              rep_edge;
  logic              seal_done;
  logic [CORK_W:0]   cork_sum;
  logic [CORK_W-1:0] rolhas_next;

  always_comb begin
    rep_edge  = rep & ~rep_q;
    seal_done = (state == SEAL) && (seal_timer == SEAL_LAST);
    // One bit of headroom so decrement and refill combine before saturating.
    cork_sum  = {1'b0, rolhas}
              - ((seal_done && (rolhas != '0)) ? (CORK_W + 1)'(1) : '0)
              + (rep_edge ? REFILL_EXT : '0);
    rolhas_next = (cork_sum > MAX_EXT) ? MAX_EXT[CORK_W-1:0] : cork_sum[CORK_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (enable) state_next = MOVE;
      MOVE: begin
        if (!enable)        state_next = IDLE;
        else if (pg && !eb) state_next = FILL;
      end
      FILL: begin
        if (ch)                                 state_next = (rolhas != '0) ? SEAL : NOCORK;
        else if (!eb && fill_timer == FILL_LAST) state_next = FAULT;
        else if (!enable)                       state_next = IDLE;
      end
      SEAL:   if (seal_done) state_next = EXIT;
      NOCORK: if (rolhas != '0) state_next = SEAL;
      EXIT:   if (!pg) state_next = enable ? MOVE : IDLE;
      FAULT:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m   = 1'b0;
    ev  = 1'b0;
    ve  = 1'b0;
    al  = 1'b0;
    flt = 1'b0;
    case (state)
      MOVE, EXIT: m   = ~eb;
      FILL:       ev  = ~eb;
      SEAL:       ve  = 1'b1;
      NOCORK:     al  = 1'b1;
      FAULT:      flt = 1'b1;
      default:    ;
    endcase
    estado = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill_timer <= '0;
      seal_timer <= '0;
      rep_q      <= 1'b0;
      rolhas     <= INIT_VAL;
      garrafas   <= '0;
    end else begin
      state  <= state_next;
      rep_q  <= rep;
      rolhas <= rolhas_next;
      // Timers idle at zero outside their state, so every entry starts a fresh count.
      if (state != FILL)  fill_timer <= '0;
      else if (!eb)       fill_timer <= fill_timer + 1'b1;
      if (state != SEAL)  seal_timer <= '0;
      else                seal_timer <= seal_timer + 1'b1;
      if (seal_done)      garrafas <= garrafas + 1'b1;
    end
  end

endmodule

// File: tb/tb_modulo_mef_enchimento_vedacao_temporizada.sv
// Directed bench for the fill/seal controller with default parameters.
module tb_modulo_mef_enchimento_vedacao_temporizada;
  logic       clk = 1'b0;
  logic       rst, enable, pg, ch, eb, rep;
  logic       m, ev, ve, al, flt;
  logic [6:0] rolhas;
  logic [7:0] garrafas;
  logic [2:0] estado;
  int checks   = 0;
  int failures = 0;

  modulo_mef_enchimento_vedacao_temporizada dut (
    .clk(clk), .rst(rst), .enable(enable), .pg(pg), .ch(ch), .eb(eb), .rep(rep),
    .m(m), .ev(ev), .ve(ve), .al(al), .flt(flt),
    .rolhas(rolhas), .garrafas(garrafas), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({m, ev, ve, al, flt});
  endfunction

  task automatic pulse_rep();
    rep = 1'b1; tick();
    rep = 1'b0; tick();
  endtask

  // IDLE -> MOVE -> FILL -> SEAL(4) -> EXIT -> IDLE, assumes corks available.
  task automatic bottle();
    enable = 1'b1; tick();
    pg = 1'b1;     tick();
    ch = 1'b1;     tick();
    ch = 1'b0;     ticks(4);
    pg = 1'b0; enable = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pg = 1'b0; ch = 1'b0; eb = 1'b0; rep = 1'b0;
    ticks(2);
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_outs", outs(), 32'b00000);
    chk("rst_rolhas", 32'(rolhas), 32'd0);
    chk("rst_garrafas", 32'(garrafas), 32'd0);
    rst = 1'b0; tick();

    // basic bottle
    rep = 1'b1; tick();
    chk("t1_refill", 32'(rolhas), 32'd15);
    ticks(2);
    chk("t1_rep_held", 32'(rolhas), 32'd15);
    rep = 1'b0; tick();
    enable = 1'b1; tick();
    chk("t1_move", 32'(estado), 32'd1);
    chk("t1_move_m", outs(), 32'b10000);
    pg = 1'b1; tick();
    chk("t1_fill_ev", outs(), 32'b01000);
    ch = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_seal_ve", outs(), 32'b00100);
      chk("t1_seal_st", 32'(estado), 32'd3);
      tick();
    end
    chk("t1_exit", 32'(estado), 32'd5);
    chk("t1_exit_m", outs(), 32'b10000);
    chk("t1_rolhas", 32'(rolhas), 32'd14);
    chk("t1_garrafas", 32'(garrafas), 32'd1);
    pg = 1'b0; ch = 1'b0; tick();
    chk("t1_exit_move", 32'(estado), 32'd1);

    // no corks
    enable = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    enable = 1'b1; tick();
    pg = 1'b1; tick();
    ch = 1'b1; tick();
    chk("t2_nocork", 32'(estado), 32'd4);
    chk("t2_al", outs(), 32'b00010);
    ch = 1'b0; enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_al_held", outs(), 32'b00010);
    end
    rep = 1'b1; tick();
    chk("t2_still_nocork", 32'(estado), 32'd4);
    chk("t2_refill", 32'(rolhas), 32'd15);
    rep = 1'b0; tick();
    chk("t2_seal", 32'(estado), 32'd3);
    chk("t2_ve", outs(), 32'b00100);
    ticks(4);
    chk("t2_exit", 32'(estado), 32'd5);
    chk("t2_rolhas", 32'(rolhas), 32'd14);
    chk("t2_garrafas", 32'(garrafas), 32'd1);
    pg = 1'b0; tick();
    chk("t2_exit_idle", 32'(estado), 32'd0);

    // fill timeout
    enable = 1'b1; tick();
    pg = 1'b1; tick();
    ticks(63);
    chk("t3_fill_63", 32'(estado), 32'd2);
    tick();
    chk("t3_fault", 32'(estado), 32'd6);
    chk("t3_flt", outs(), 32'b00001);
    enable = 1'b0; tick();
    chk("t3_fault_idle", 32'(estado), 32'd0);
    chk("t3_idle_outs", outs(), 32'b00000);
    enable = 1'b1; tick();
    tick();
    ticks(20);
    eb = 1'b1; #1;
    chk("t3_eb_valve", outs(), 32'b00000);
    chk("t3_eb_state", 32'(estado), 32'd2);
    ticks(10);
    eb = 1'b0; ticks(43);
    chk("t3_fill_73", 32'(estado), 32'd2);
    tick();
    chk("t3_fault_74", 32'(estado), 32'd6);
    enable = 1'b0; pg = 1'b0; tick();
    chk("t3_idle2", 32'(estado), 32'd0);

    // cork saturation and refill timing
    for (int i = 0; i < 5; i++) pulse_rep();
    chk("t4_r89", 32'(rolhas), 32'd89);
    pulse_rep();
    chk("t4_sat100", 32'(rolhas), 32'd100);
    for (int i = 0; i < 5; i++) bottle();
    chk("t4_r95", 32'(rolhas), 32'd95);
    chk("t4_g6", 32'(garrafas), 32'd6);
    rep = 1'b1; tick();
    chk("t4_95_to_100", 32'(rolhas), 32'd100);
    ticks(5);
    chk("t4_held_100", 32'(rolhas), 32'd100);
    rep = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    pulse_rep();
    for (int i = 0; i < 14; i++) bottle();
    chk("t4_r1", 32'(rolhas), 32'd1);
    chk("t4_g14", 32'(garrafas), 32'd14);
    enable = 1'b1; tick();
    pg = 1'b1; tick();
    ch = 1'b1; tick();
    ch = 1'b0; ticks(3);
    chk("t4_last_seal", 32'(estado), 32'd3);
    rep = 1'b1; tick();
    chk("t4_exit", 32'(estado), 32'd5);
    chk("t4_dec_refill", 32'(rolhas), 32'd15);
    chk("t4_g15", 32'(garrafas), 32'd15);
    rep = 1'b0; pg = 1'b0; enable = 1'b0; tick();

    // bottle counter wrap
    for (int i = 0; i < 240; i++) begin
      pulse_rep();
      bottle();
    end
    chk("t5_r99", 32'(rolhas), 32'd99);
    chk("t5_g255", 32'(garrafas), 32'd255);
    bottle();
    chk("t5_wrap", 32'(garrafas), 32'd0);
    chk("t5_r98", 32'(rolhas), 32'd98);

    // conveyor blocked
    enable = 1'b1; tick();
    chk("t5_move_m", outs(), 32'b10000);
    eb = 1'b1; #1;
    chk("t5_move_eb", outs(), 32'b00000);
    pg = 1'b1; tick();
    chk("t5_move_held", 32'(estado), 32'd1);
    eb = 1'b0; #1;
    chk("t5_move_m2", outs(), 32'b10000);
    tick();
    chk("t5_fill", 32'(estado), 32'd2);
    ch = 1'b1; tick();
    ch = 1'b0; ticks(4);
    chk("t5_exit", 32'(estado), 32'd5);
    eb = 1'b1; #1;
    chk("t5_exit_eb", outs(), 32'b00000);
    tick();
    chk("t5_exit_held", 32'(estado), 32'd5);
    eb = 1'b0; pg = 1'b0; tick();
    chk("t5_exit_move", 32'(estado), 32'd1);
    chk("t5_g1", 32'(garrafas), 32'd1);
    chk("t5_r97", 32'(rolhas), 32'd97);

    // reset during seal
    pg = 1'b1; tick();
    ch = 1'b1; tick();
    ch = 1'b0; tick();
    chk("t5_seal_ve", outs(), 32'b00100);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_state", 32'(estado), 32'd0);
    chk("t5_rst_outs", outs(), 32'b00000);
    chk("t5_rst_rolhas", 32'(rolhas), 32'd0);
    chk("t5_rst_garrafas", 32'(garrafas), 32'd0);
    enable = 1'b0; pg = 1'b0; tick();
    rst = 1'b0; tick();
    chk("t5_post_rst", 32'(estado), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
